// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results and FIFO-buffered load returns share one register-file write port.
// The register-file write lands one cycle after grant; the ALU stalls on contention, and the load unit stalls only when the FIFO is full.
module wb_arbiter #(
    parameter int DEPTH = 4,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             alu_valid,
    input  logic [4:0]       alu_rd,
    input  logic [63:0]      alu_data,
    output logic             alu_ready,
    input  logic             ld_valid,
    input  logic [4:0]       ld_rd,
    input  logic [63:0]      ld_data,
    output logic             ld_ready,
    output logic [PTR_W:0]   ld_count,
    output logic [4:0]       rd,
    output logic [63:0]      wdata,
    output logic             RegWrite
);

    logic [4:0]       fifo_rd  [DEPTH];
    logic [63:0]      fifo_dat [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             prio_alu;

    logic             lp;
    logic             contend;
    logic             grant_alu;
    logic             grant_ld;
    logic             push;
    logic             pop;
    logic [4:0]       sel_rd;
    logic [63:0]      sel_dat;

    assign lp        = (ld_count != '0);
    assign ld_ready  = (ld_count != (PTR_W+1)'(DEPTH));
    assign contend   = alu_valid && lp;
    assign grant_alu = alu_valid && (!lp || prio_alu);
    assign grant_ld  = lp && (!alu_valid || !prio_alu);
    assign alu_ready = grant_alu;
    assign push      = ld_valid && ld_ready;
    assign pop       = grant_ld;

    assign sel_rd  = grant_alu ? alu_rd   : fifo_rd[rptr];
    assign sel_dat = grant_alu ? alu_data : fifo_dat[rptr];

    // Storage needs no reset: occupancy is tracked by ld_count alone.
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_rd[wptr]  <= ld_rd;
            fifo_dat[wptr] <= ld_data;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            wptr     <= '0;
            rptr     <= '0;
            ld_count <= '0;
            prio_alu <= 1'b1;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   ld_count <= ld_count + (PTR_W+1)'(1);
                2'b01:   ld_count <= ld_count - (PTR_W+1)'(1);
                default: ld_count <= ld_count;
            endcase
            if (contend) begin
                prio_alu <= !prio_alu;
            end
        end
    end

    // Writes to x0 still complete the handshake but never raise RegWrite.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            rd       <= '0;
            wdata    <= '0;
            RegWrite <= 1'b0;
        end else if (grant_alu || grant_ld) begin
            rd       <= sel_rd;
            wdata    <= sel_dat;
            RegWrite <= (sel_rd != 5'd0);
        end else begin
            RegWrite <= 1'b0;
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: a per-cycle arbitration model feeds a write scoreboard checked by a monitor.
module tb_wb_arbiter;

    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [63:0] alu_data;
    logic        alu_ready;
    logic        ld_valid;
    logic [4:0]  ld_rd;
    logic [63:0] ld_data;
    logic        ld_ready;
    logic [2:0]  ld_count;
    logic [4:0]  rd;
    logic [63:0] wdata;
    logic        RegWrite;

    typedef struct packed {
        logic [4:0]  rd;
        logic [63:0] dat;
    } wr_t;

    wr_t exp_q[$];
    wr_t ldq[$];
    bit  prio_m;
    int  tests = 0;
    int  fails = 0;
    int  cont_exp[5] = '{20, 10, 21, 11, 22};

    always #5 CLK = ~CLK;

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .CLK(CLK), .nRST(nRST),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data), .alu_ready(alu_ready),
        .ld_valid(ld_valid), .ld_rd(ld_rd), .ld_data(ld_data), .ld_ready(ld_ready),
        .ld_count(ld_count), .rd(rd), .wdata(wdata), .RegWrite(RegWrite)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [63:0] adat(input int r);
        return 64'hA100_0000_0000_0000 + 64'(r);
    endfunction

    function automatic logic [63:0] ldat(input int r);
        return 64'h1D00_0000_0000_0000 + 64'(r);
    endfunction

    // One clock cycle with the currently driven inputs; predicts grants and queues expected writes.
    task automatic cycle(output bit a_acc, output bit l_acc, output bit dut_ar);
        bit  lp, full, g_alu, g_ld;
        wr_t e;
        lp    = (ldq.size() != 0);
        full  = (ldq.size() == DEPTH);
        g_alu = alu_valid && (!lp || prio_m);
        g_ld  = lp && (!alu_valid || !prio_m);
        #1;
        dut_ar = alu_ready;
        chk("alu_ready", {63'b0, alu_ready}, {63'b0, g_alu});
        chk("ld_ready", {63'b0, ld_ready}, {63'b0, !full});
        chk("ld_count", 64'(ld_count), 64'(ldq.size()));
        if (g_alu && alu_rd != 5'd0) begin
            e.rd = alu_rd; e.dat = alu_data;
            exp_q.push_back(e);
        end
        if (g_ld) begin
            e = ldq.pop_front();
            if (e.rd != 5'd0) exp_q.push_back(e);
        end
        if (alu_valid && lp) prio_m = !prio_m;
        l_acc = ld_valid && !full;
        if (l_acc) begin
            e.rd = ld_rd; e.dat = ld_data;
            ldq.push_back(e);
        end
        a_acc = g_alu;
        @(posedge CLK);
        #1;
    endtask

    always @(negedge CLK) begin
        if (nRST === 1'b1 && RegWrite === 1'b1) begin
            tests++;
            assert (exp_q.size() > 0) else begin
                fails++;
                $error("FAIL unexpected_write: observed rd=%0d data=%h expected no write", rd, wdata);
            end
            if (exp_q.size() > 0) begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_rd", 64'(rd), 64'(e.rd));
                chk("wr_data", wdata, e.dat);
            end
        end
    end

    initial begin
        #100000;
        fails++;
        $display("FAIL timeout: observed no finish expected finish");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

    initial begin
        bit a, l, ar;
        int ai, li;
        logic [4:0] acc_pat;
        int seen[$];

        nRST = 1'b0; alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
        ld_valid = 1'b0; ld_rd = '0; ld_data = '0;
        prio_m = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_regwrite", {63'b0, RegWrite}, 64'd0);
        chk("rst_rd", 64'(rd), 64'd0);
        chk("rst_wdata", wdata, 64'd0);
        chk("rst_count", 64'(ld_count), 64'd0);
        chk("rst_ld_ready", {63'b0, ld_ready}, 64'd1);
        nRST = 1'b1;
        @(posedge CLK); #1;

        // ALU only
        alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 64'h0000_0000_DEAD_BEEF;
        cycle(a, l, ar);
        chk("alu_only_ready", {63'b0, ar}, 64'd1);
        alu_valid = 1'b0;
        chk("alu_only_we", {63'b0, RegWrite}, 64'd1);
        chk("alu_only_rd", 64'(rd), 64'd5);
        chk("alu_only_wdata", wdata, 64'h0000_0000_DEAD_BEEF);
        cycle(a, l, ar);
        chk("alu_only_we_off", {63'b0, RegWrite}, 64'd0);

        // x0 suppression, ALU then load
        alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 64'h1234;
        cycle(a, l, ar);
        chk("x0_alu_ready", {63'b0, ar}, 64'd1);
        alu_valid = 1'b0;
        chk("x0_alu_we", {63'b0, RegWrite}, 64'd0);
        chk("x0_alu_wdata", wdata, 64'h1234);
        ld_valid = 1'b1; ld_rd = 5'd0; ld_data = 64'h55;
        cycle(a, l, ar);
        ld_valid = 1'b0;
        chk("x0_ld_count1", 64'(ld_count), 64'd1);
        cycle(a, l, ar);
        chk("x0_ld_count0", 64'(ld_count), 64'd0);
        chk("x0_ld_we", {63'b0, RegWrite}, 64'd0);
        chk("x0_ld_wdata", wdata, 64'h55);

        // Contention alternation: loads 10,11 against ALU 20,21,22
        ld_valid = 1'b1; ld_rd = 5'd10; ld_data = ldat(10);
        cycle(a, l, ar);
        ai = 0; acc_pat = '0;
        alu_valid = 1'b1; ld_rd = 5'd11; ld_data = ldat(11);
        for (int k = 0; k < 5; k++) begin
            ld_valid = (k == 0);
            alu_rd = 5'(20 + ai); alu_data = adat(20 + ai);
            cycle(a, l, ar);
            acc_pat = {acc_pat[3:0], ar};
            if (a) ai++;
            if (RegWrite) seen.push_back(int'(rd));
        end
        alu_valid = 1'b0; ld_valid = 1'b0;
        chk("cont_stall_pattern", 64'(acc_pat), 64'b10101);
        chk("cont_write_count", 64'(seen.size()), 64'd5);
        for (int k = 0; k < 5 && k < seen.size(); k++)
            chk("cont_seq", 64'(seen[k]), 64'(cont_exp[k]));

        // Simultaneous push and pop at count 2
        ld_valid = 1'b1; ld_rd = 5'd24; ld_data = ldat(24);
        cycle(a, l, ar);
        ld_rd = 5'd25; ld_data = ldat(25);
        alu_valid = 1'b1; alu_rd = 5'd27; alu_data = adat(27);
        cycle(a, l, ar);
        alu_valid = 1'b0; ld_rd = 5'd26; ld_data = ldat(26);
        chk("pushpop_count_before", 64'(ld_count), 64'd2);
        cycle(a, l, ar);
        chk("pushpop_count_after", 64'(ld_count), 64'd2);
        ld_valid = 1'b0;
        repeat (4) cycle(a, l, ar);
        chk("pushpop_drained", 64'(ld_count), 64'd0);

        // Fill to full under continuous ALU contention; held load must enter once space frees
        ai = 0; li = 0;
        for (int k = 0; k < 60 && li < 8; k++) begin
            alu_valid = 1'b1; alu_rd = 5'(16 + ai % 8); alu_data = adat(100 + ai);
            ld_valid = 1'b1; ld_rd = 5'(1 + li); ld_data = ldat(1 + li);
            cycle(a, l, ar);
            if (a) ai++;
            if (l) li++;
        end
        chk("fill_loads_accepted", 64'(li), 64'd8);
        alu_valid = 1'b0; ld_valid = 1'b0;
        repeat (8) cycle(a, l, ar);
        chk("fill_drained", 64'(ld_count), 64'd0);

        // Reset mid-stream with three loads buffered
        li = 0;
        for (int k = 0; k < 20 && ldq.size() < 3; k++) begin
            alu_valid = 1'b1; alu_rd = 5'(16 + ai % 8); alu_data = adat(100 + ai);
            ld_valid = 1'b1; ld_rd = 5'(9 + li); ld_data = ldat(9 + li);
            cycle(a, l, ar);
            if (a) ai++;
            if (l) li++;
        end
        chk("pre_reset_count", 64'(ld_count), 64'd3);
        alu_valid = 1'b0; ld_valid = 1'b0; nRST = 1'b0;
        #1;
        chk("mid_rst_regwrite", {63'b0, RegWrite}, 64'd0);
        chk("mid_rst_rd", 64'(rd), 64'd0);
        chk("mid_rst_wdata", wdata, 64'd0);
        chk("mid_rst_count", 64'(ld_count), 64'd0);
        chk("mid_rst_ld_ready", {63'b0, ld_ready}, 64'd1);
        ldq.delete(); exp_q.delete(); prio_m = 1'b1;
        @(posedge CLK); #1;
        nRST = 1'b1;
        @(posedge CLK); #1;
        alu_valid = 1'b1; alu_rd = 5'd7; alu_data = adat(7);
        cycle(a, l, ar);
        chk("post_rst_alu_ready", {63'b0, ar}, 64'd1);
        alu_valid = 1'b0;
        repeat (2) cycle(a, l, ar);

        chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
